// File: rtl/fix_compid_serializer_if.sv
// Bundle of the CompID header stream: session config and start on one side, byte stream out the other.
// master = serializer side, slave = config/consumer side.
`timescale 1ns/1ps
interface fix_compid_serializer_if #(
  parameter int VALUE_WIDTH = 256,
  parameter int WIDTH_SIZE  = 5
);
  logic                   start_i;
  logic [VALUE_WIDTH-1:0] senderCompId_i;
  logic [VALUE_WIDTH-1:0] targetCompId_i;
  logic [WIDTH_SIZE-1:0]  sizeSenderId_i;
  logic [WIDTH_SIZE-1:0]  sizeTargetId_i;
  logic [7:0]             data_o;
  logic                   valid_o;
  logic                   ready_i;
  logic                   last_o;
  logic                   busy_o;
  logic                   done_o;

  modport master (
    input  start_i,
    input  senderCompId_i,
    input  targetCompId_i,
    input  sizeSenderId_i,
    input  sizeTargetId_i,
    input  ready_i,
    output data_o,
    output valid_o,
    output last_o,
    output busy_o,
    output done_o
  );

  modport slave (
    output start_i,
    output senderCompId_i,
    output targetCompId_i,
    output sizeSenderId_i,
    output sizeTargetId_i,
    output ready_i,
    input  data_o,
    input  valid_o,
    input  last_o,
    input  busy_o,
    input  done_o
  );
endinterface

// File: rtl/fix_compid_serializer.sv
// Emits "49=<sender><SOH>56=<target><SOH>" as a valid/ready byte stream from latched CompIDs.
// Optional FIX_SEP_PIPE_EN: separators become '|' (0x7C) for readable debug logs.
`timescale 1ns/1ps
module fix_compid_serializer #(
  parameter int VALUE_WIDTH = 256,
  parameter int WIDTH_SIZE  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fix_compid_serializer_if.master  bus
);

  localparam int NBYTES = VALUE_WIDTH / 8;
  localparam int IW     = WIDTH_SIZE + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] S_TAG = 3'd1;
  localparam logic [2:0] S_ID  = 3'd2;
  localparam logic [2:0] S_SEP = 3'd3;
  localparam logic [2:0] T_TAG = 3'd4;
  localparam logic [2:0] T_ID  = 3'd5;
  localparam logic [2:0] T_SEP = 3'd6;

  localparam logic [IW-1:0] IDX_ZERO = '0;
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] TAG_LAST = IW'(2);

`ifdef FIX_SEP_PIPE_EN
  localparam logic [7:0] SEP_BYTE = 8'h7C;
`else
  localparam logic [7:0] SEP_BYTE = 8'h01;
`endif

  logic [2:0]             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [VALUE_WIDTH-1:0] sender_q, sender_d;
  logic [VALUE_WIDTH-1:0] target_q, target_d;
  logic [WIDTH_SIZE-1:0]  size_s_q, size_s_d;
  logic [WIDTH_SIZE-1:0]  size_t_q, size_t_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   xfer;
  logic                   accept;
  logic [7:0]             sender_bytes [NBYTES];
  logic [7:0]             target_bytes [NBYTES];

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
    assign sender_bytes[gi] = sender_q[8*gi +: 8];
    assign target_bytes[gi] = target_q[8*gi +: 8];
  end

  assign xfer   = valid_q & bus.ready_i;
  assign accept = (state_q == IDLE) & bus.start_i;

  // Sequencing: every state change clears the shared index.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sender_d = sender_q;
    target_d = target_q;
    size_s_d = size_s_q;
    size_t_d = size_t_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = S_TAG;
          idx_d    = IDX_ZERO;
          sender_d = bus.senderCompId_i;
          target_d = bus.targetCompId_i;
          size_s_d = bus.sizeSenderId_i;
          size_t_d = bus.sizeTargetId_i;
        end
      end
      S_TAG: begin
        if (xfer) begin
          if (idx_q == TAG_LAST) begin
            state_d = S_ID;
            idx_d   = IDX_ZERO;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      S_ID: begin
        if (xfer) begin
          if (idx_q == {1'b0, size_s_q}) begin
            state_d = S_SEP;
            idx_d   = IDX_ZERO;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      S_SEP: begin
        if (xfer) begin
          state_d = T_TAG;
          idx_d   = IDX_ZERO;
        end
      end
      T_TAG: begin
        if (xfer) begin
          if (idx_q == TAG_LAST) begin
            state_d = T_ID;
            idx_d   = IDX_ZERO;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      T_ID: begin
        if (xfer) begin
          if (idx_q == {1'b0, size_t_q}) begin
            state_d = T_SEP;
            idx_d   = IDX_ZERO;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      T_SEP: begin
        if (xfer) begin
          state_d = IDLE;
          idx_d   = IDX_ZERO;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = IDX_ZERO;
      end
    endcase
  end

  // Output byte is decoded from the next state/index so it lands in data_q with that state.
  always_comb begin
    data_d = 8'h00;
    case (state_d)
      S_TAG: begin
        if (idx_d == IDX_ZERO)     data_d = 8'h34;
        else if (idx_d == IDX_ONE) data_d = 8'h39;
        else                       data_d = 8'h3D;
      end
      T_TAG: begin
        if (idx_d == IDX_ZERO)     data_d = 8'h35;
        else if (idx_d == IDX_ONE) data_d = 8'h36;
        else                       data_d = 8'h3D;
      end
      S_ID:    data_d = sender_bytes[idx_d[WIDTH_SIZE-1:0]];
      T_ID:    data_d = target_bytes[idx_d[WIDTH_SIZE-1:0]];
      S_SEP:   data_d = SEP_BYTE;
      T_SEP:   data_d = SEP_BYTE;
      default: data_d = 8'h00;
    endcase
  end

  always_comb begin
    valid_d = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
    last_d  = (state_d == T_SEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= IDX_ZERO;
      sender_q <= '0;
      target_q <= '0;
      size_s_q <= '0;
      size_t_q <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sender_q <= sender_d;
      target_q <= target_d;
      size_s_q <= size_s_d;
      size_t_q <= size_t_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.last_o  = last_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_fix_compid_serializer.sv
// Randomized self-checking bench for fix_compid_serializer against a queue-based frame model.
// Build with FIX_SEP_PIPE_EN to exercise the '|' separator variant.
`timescale 1ns/1ps
module tb_fix_compid_serializer;
  localparam int VW = 256;
  localparam int WS = 5;
`ifdef FIX_SEP_PIPE_EN
  localparam logic [7:0] SEP = 8'h7C;
`else
  localparam logic [7:0] SEP = 8'h01;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fix_compid_serializer_if #(.VALUE_WIDTH(VW), .WIDTH_SIZE(WS)) bus ();
  fix_compid_serializer #(.VALUE_WIDTH(VW), .WIDTH_SIZE(WS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [VW-1:0] rand_id();
    logic [VW-1:0] r;
    for (int i = 0; i < VW/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference frame: tag, ID bytes low-first, separator, tag, ID bytes, separator.
  task automatic build_expected(input logic [VW-1:0] s, input logic [VW-1:0] t,
                                input int ss, input int st, output logic [7:0] q[$]);
    q = {};
    q.push_back(8'h34); q.push_back(8'h39); q.push_back(8'h3D);
    for (int k = 0; k <= ss; k++) q.push_back(s[8*k +: 8]);
    q.push_back(SEP);
    q.push_back(8'h35); q.push_back(8'h36); q.push_back(8'h3D);
    for (int k = 0; k <= st; k++) q.push_back(t[8*k +: 8]);
    q.push_back(SEP);
  endtask

  // Called at a negedge; returns one negedge later with inputs scrambled to prove latching.
  task automatic drive_start(input logic [VW-1:0] s, input logic [VW-1:0] t, input int ss, input int st);
    bus.start_i        = 1'b1;
    bus.senderCompId_i = s;
    bus.targetCompId_i = t;
    bus.sizeSenderId_i = WS'(ss);
    bus.sizeTargetId_i = WS'(st);
    @(negedge clk);
    bus.start_i        = 1'b0;
    bus.senderCompId_i = rand_id();
    bus.targetCompId_i = rand_id();
    bus.sizeSenderId_i = WS'($urandom);
    bus.sizeTargetId_i = WS'($urandom);
  endtask

  // Gathers transferred bytes until last_o transfers, then samples the following cycle.
  // mode 0: ready always, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic collect(input int mode, input int start_at, output logic [7:0] q[$],
                         output int stream_err, output bit done_ok, output bit timed_out);
    logic [7:0] prev_data;
    bit prev_stall, prev_last, rdy, finished;
    int cyc;
    q = {}; stream_err = 0; done_ok = 0; timed_out = 0;
    prev_stall = 0; prev_last = 0; prev_data = 8'h00; finished = 0; cyc = 0;
    while (!finished) begin
      if (cyc >= 1000) begin
        timed_out = 1;
        break;
      end
      if (bus.valid_o !== 1'b1) stream_err++;
      if (prev_stall && (bus.data_o !== prev_data || bus.last_o !== prev_last)) stream_err++;
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      else                rdy = 1'($urandom_range(0, 1));
      bus.ready_i = rdy;
      bus.start_i = (start_at >= 0) && (q.size() == start_at);
      if (bus.start_i) begin
        bus.senderCompId_i = rand_id();
        bus.targetCompId_i = rand_id();
        bus.sizeSenderId_i = WS'($urandom);
        bus.sizeTargetId_i = WS'($urandom);
      end
      prev_stall = bus.valid_o && !rdy;
      prev_data  = bus.data_o;
      prev_last  = bus.last_o;
      if (bus.valid_o && rdy) begin
        q.push_back(bus.data_o);
        if (bus.last_o) finished = 1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start_i = 1'b0;
    bus.ready_i = 1'b1;
    done_ok = !timed_out && bus.done_o === 1'b1 && bus.valid_o === 1'b0 &&
              bus.busy_o === 1'b0 && bus.last_o === 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_i = 1'b1;
    bus.ready_i = 1'b1;
    bus.senderCompId_i = '0; bus.targetCompId_i = '0;
    bus.sizeSenderId_i = '0; bus.sizeTargetId_i = '0;
    #12;
    checks++;
    if ({bus.valid_o, bus.busy_o, bus.last_o, bus.done_o, bus.data_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got v=%b b=%b l=%b d=%b data=%h, need all 0", bus.valid_o, bus.busy_o, bus.last_o, bus.done_o, bus.data_o);
    end
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: valid=%b, need 0", bus.valid_o);
    end
    bus.start_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_release: valid=%b busy=%b, need 0 0", bus.valid_o, bus.busy_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic(input int mode, input string name);
    logic [VW-1:0] s, t;
    logic [7:0] got[$], exp[$];
    int serr, bad;
    bit dok, tmo;
    s = rand_id(); t = rand_id();
    s[15:0] = 16'h4241; t[7:0] = 8'h58;
    build_expected(s, t, 1, 0, exp);
    drive_start(s, t, 1, 0);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.data_o !== 8'h34) begin
      errors++;
      $display("FAIL %s_first_byte: v=%b b=%b data=%h, need 1 1 34", name, bus.valid_o, bus.busy_o, bus.data_o);
    end
    collect(mode, -1, got, serr, dok, tmo);
    bad = -1;
    for (int i = 0; i < exp.size() && i < got.size(); i++) if (bad < 0 && got[i] !== exp[i]) bad = i;
    checks++;
    if (got.size() != 11 || bad >= 0) begin
      errors++;
      $display("FAIL %s_stream: len=%0d first_bad=%0d got=%p, need %p", name, got.size(), bad, got, exp);
    end
    checks++;
    if (serr != 0 || tmo) begin
      errors++;
      $display("FAIL %s_stability: stream_err=%0d timeout=%0d, need 0 0", name, serr, tmo);
    end
    checks++;
    if (!dok) begin
      errors++;
      $display("FAIL %s_done: done=%b valid=%b busy=%b, need 1 0 0", name, bus.done_o, bus.valid_o, bus.busy_o);
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse_width: done=%b, need 0", name, bus.done_o);
    end
    $display("%s frame: %0d bytes", name, got.size());
  endtask

  task automatic test_max_len();
    logic [VW-1:0] s, t;
    logic [7:0] got[$], exp[$];
    int serr, bad;
    bit dok, tmo;
    for (int k = 0; k < 32; k++) begin
      s[8*k +: 8] = 8'(k);
      t[8*k +: 8] = 8'(k + 32);
    end
    build_expected(s, t, 31, 31, exp);
    drive_start(s, t, 31, 31);
    collect(0, -1, got, serr, dok, tmo);
    bad = -1;
    for (int i = 0; i < exp.size() && i < got.size(); i++) if (bad < 0 && got[i] !== exp[i]) bad = i;
    checks++;
    if (got.size() != 72 || bad >= 0) begin
      errors++;
      $display("FAIL max_len_stream: len=%0d need 72, first_bad=%0d", got.size(), bad);
    end
    checks++;
    if (serr != 0 || !dok) begin
      errors++;
      $display("FAIL max_len_done: stream_err=%0d done_ok=%0d, need 0 1", serr, dok);
    end
    @(negedge clk);
    $display("max_len frame: %0d bytes", got.size());
  endtask

  task automatic test_start_while_busy();
    logic [VW-1:0] s, t;
    logic [7:0] got[$], exp[$];
    int serr, ss, st;
    bit dok, tmo;
    s = rand_id(); t = rand_id(); ss = 3; st = 2;
    build_expected(s, t, ss, st, exp);
    drive_start(s, t, ss, st);
    collect(0, 5, got, serr, dok, tmo);
    checks++;
    if (got != exp || serr != 0 || !dok) begin
      errors++;
      $display("FAIL busy_start_frame: got=%p need=%p serr=%0d done_ok=%0d", got, exp, serr, dok);
    end
    @(negedge clk); @(negedge clk); @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_not_queued: valid=%b busy=%b, need 0 0", bus.valid_o, bus.busy_o);
    end
    // Frame ending in a done cycle that immediately accepts the next start.
    s = rand_id(); t = rand_id(); ss = 0; st = 1;
    build_expected(s, t, ss, st, exp);
    drive_start(s, t, ss, st);
    collect(0, -1, got, serr, dok, tmo);
    checks++;
    if (!dok) begin
      errors++;
      $display("FAIL done_cycle_reached: done=%b, need 1", bus.done_o);
    end
    s = rand_id(); t = rand_id(); ss = $urandom_range(0, 31); st = $urandom_range(0, 31);
    build_expected(s, t, ss, st, exp);
    drive_start(s, t, ss, st);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h34) begin
      errors++;
      $display("FAIL start_in_done_cycle: valid=%b data=%h, need 1 34", bus.valid_o, bus.data_o);
    end
    collect(0, -1, got, serr, dok, tmo);
    checks++;
    if (got != exp || !dok) begin
      errors++;
      $display("FAIL done_cycle_frame: len=%0d need %0d done_ok=%0d", got.size(), exp.size(), dok);
    end
    @(negedge clk);
    $display("start_while_busy frame: %0d bytes", got.size());
  endtask

  task automatic test_reset_midstream();
    logic [VW-1:0] s, t;
    s = rand_id(); t = rand_id();
    bus.ready_i = 1'b1;
    drive_start(s, t, 2, 4);
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.valid_o, bus.busy_o, bus.last_o, bus.done_o, bus.data_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_midstream: v=%b b=%b l=%b d=%b data=%h, need all 0", bus.valid_o, bus.busy_o, bus.last_o, bus.done_o, bus.data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.done_o !== 1'b0 || bus.last_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: v=%b d=%b l=%b, need 0 0 0", bus.valid_o, bus.done_o, bus.last_o);
    end
    $display("reset_midstream applied");
  endtask

  task automatic test_random_frames();
    logic [VW-1:0] s, t;
    logic [7:0] got[$], exp[$];
    int serr, ss, st;
    bit dok, tmo;
    for (int n = 0; n < 8; n++) begin
      s = rand_id(); t = rand_id();
      ss = $urandom_range(0, 31); st = $urandom_range(0, 31);
      build_expected(s, t, ss, st, exp);
      drive_start(s, t, ss, st);
      collect(2, -1, got, serr, dok, tmo);
      checks++;
      if (got != exp || got.size() != ss + st + 10) begin
        errors++;
        $display("FAIL random_frame_%0d: len=%0d need %0d got=%p", n, got.size(), ss + st + 10, got);
      end
      checks++;
      if (serr != 0 || !dok || tmo) begin
        errors++;
        $display("FAIL random_frame_%0d_ctrl: serr=%0d done_ok=%0d timeout=%0d", n, serr, dok, tmo);
      end
      $display("random frame %0d: ss=%0d st=%0d bytes=%0d", n, ss, st, got.size());
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_basic(0, "basic");
    test_max_len();
    test_basic(1, "backpressure");
    test_start_while_busy();
    test_reset_midstream();
    test_basic(0, "after_reset");
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, need completion");
    $fatal(1, "watchdog expired");
  end

endmodule
